state_taker: RTL and testbench

//  Receiver for the debug state byte stream emitted once per frame by the ntcrackfpga core.

---
 rtl/state_taker.sv | 275 +++++++++++++++++++++++++++
 tb/tb_state_taker.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/state_taker.sv
// state_taker: debug state byte-stream receiver with atomic frame commit.
// Ports: clk, nrst (sync, active-low), byte_in/byte_valid in; decoded fields, frame_ok/err, locked, err_count out.
module state_taker #(
  parameter int HASH_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic [4:0]              password_len,
  output logic [159:0]            password_chars,
  output logic [8*HASH_BYTES-1:0] hashes_window,
  output logic [127:0]            current_hash,
  output logic [4:0]              ntcrackfpga_state,
  output logic [3:0]              hashchecker_state,
  output logic [5:0]              md4block_step,
  output logic                    frame_ok,
  output logic                    frame_err,
  output logic                    locked,
  output logic [7:0]              err_count
);

  localparam int HW = 8 * HASH_BYTES;

  typedef enum logic [1:0] {
    S_HDR,
    S_TYPE,
    S_PAY,
    S_FTR
  } st_t;

  st_t         st_q, st_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  typ_q, typ_d;
  logic        in_frame_q, in_frame_d;

  logic [4:0]   sh_plen_q, sh_plen_d;
  logic [159:0] sh_chars_q, sh_chars_d;
  logic [HW-1:0] sh_hash_q, sh_hash_d;
  logic [127:0] sh_cur_q, sh_cur_d;
  logic [4:0]   sh_ntc_q, sh_ntc_d;
  logic [3:0]   sh_hc_q, sh_hc_d;
  logic [5:0]   sh_md4_q, sh_md4_d;

  logic [4:0]   plen_q, plen_d;
  logic [159:0] chars_q, chars_d;
  logic [HW-1:0] hash_q, hash_d;
  logic [127:0] cur_q, cur_d;
  logic [4:0]   ntc_q, ntc_d;
  logic [3:0]   hc_q, hc_d;
  logic [5:0]   md4_q, md4_d;

  logic       ok_q, ok_d;
  logic       err_q, err_d;
  logic       locked_q, locked_d;
  logic [7:0] errc_q, errc_d;

  logic [7:0]  hdr_exp;
  logic [7:0]  ftr_exp;
  logic [15:0] pay_len;
  logic        viol;

  always_comb begin
    hdr_exp = 8'h0A;
    ftr_exp = 8'hA2;
    unique case (idx_q)
      2'd0: begin hdr_exp = 8'h0A; ftr_exp = 8'hA2; end
      2'd1: begin hdr_exp = 8'h55; ftr_exp = 8'h5E; end
      2'd2: begin hdr_exp = 8'hFA; ftr_exp = 8'hFA; end
      default: begin hdr_exp = 8'hCE; ftr_exp = 8'hCE; end
    endcase
  end

  always_comb begin
    pay_len = 16'd3;
    unique case (typ_q)
      3'd1: pay_len = 16'd1;
      3'd2: pay_len = 16'd20;
      3'd3: pay_len = 16'(HASH_BYTES);
      3'd4: pay_len = 16'd16;
      default: pay_len = 16'd3;
    endcase
  end

  always_comb begin
    st_d       = st_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    typ_d      = typ_q;
    in_frame_d = in_frame_q;
    sh_plen_d  = sh_plen_q;
    sh_chars_d = sh_chars_q;
    sh_hash_d  = sh_hash_q;
    sh_cur_d   = sh_cur_q;
    sh_ntc_d   = sh_ntc_q;
    sh_hc_d    = sh_hc_q;
    sh_md4_d   = sh_md4_q;
    plen_d     = plen_q;
    chars_d    = chars_q;
    hash_d     = hash_q;
    cur_d      = cur_q;
    ntc_d      = ntc_q;
    hc_d       = hc_q;
    md4_d      = md4_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    locked_d   = locked_q;
    errc_d     = errc_q;
    viol       = 1'b0;

    if (byte_valid) begin
      unique case (st_q)
        S_HDR: begin
          if (byte_in == hdr_exp) begin
            if (idx_q == 2'd3) begin
              st_d  = S_TYPE;
              idx_d = 2'd0;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            viol = 1'b1;
          end
        end
        S_TYPE: begin
          if (byte_in == {5'd0, typ_q}) begin
            st_d  = S_PAY;
            cnt_d = 16'd0;
            if (typ_q == 3'd1) in_frame_d = 1'b1;
          end else begin
            viol = 1'b1;
          end
        end
        S_PAY: begin
          unique case (typ_q)
            3'd1: sh_plen_d = byte_in[4:0];
            3'd2: sh_chars_d = {sh_chars_q[151:0], byte_in};
            3'd3: sh_hash_d = {sh_hash_q[HW-9:0], byte_in};
            3'd4: sh_cur_d = {sh_cur_q[119:0], byte_in};
            default: begin
              // Record 5 bytes map to three narrow fields by position.
              unique case (cnt_q[1:0])
                2'd0: sh_ntc_d = byte_in[4:0];
                2'd1: sh_hc_d = byte_in[3:0];
                default: sh_md4_d = byte_in[5:0];
              endcase
            end
          endcase
          if (cnt_q == pay_len - 16'd1) begin
            cnt_d = 16'd0;
            idx_d = 2'd0;
            if (typ_q == 3'd5) begin
              st_d = S_FTR;
            end else begin
              st_d  = S_HDR;
              typ_d = typ_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          if (byte_in == ftr_exp) begin
            if (idx_q == 2'd3) begin
              ok_d       = 1'b1;
              locked_d   = 1'b1;
              plen_d     = sh_plen_q;
              chars_d    = sh_chars_q;
              hash_d     = sh_hash_q;
              cur_d      = sh_cur_q;
              ntc_d      = sh_ntc_q;
              hc_d       = sh_hc_q;
              md4_d      = sh_md4_q;
              in_frame_d = 1'b0;
              st_d       = S_HDR;
              idx_d      = 2'd0;
              typ_d      = 3'd1;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            viol = 1'b1;
          end
        end
      endcase
    end

    if (viol) begin
      if (in_frame_q) begin
        err_d    = 1'b1;
        locked_d = 1'b0;
        errc_d   = (errc_q == 8'hFF) ? errc_q : errc_q + 8'd1;
      end
      sh_plen_d  = '0;
      sh_chars_d = '0;
      sh_hash_d  = '0;
      sh_cur_d   = '0;
      sh_ntc_d   = '0;
      sh_hc_d    = '0;
      sh_md4_d   = '0;
      in_frame_d = 1'b0;
      st_d       = S_HDR;
      typ_d      = 3'd1;
      cnt_d      = 16'd0;
      // The offending byte may itself start a new header.
      idx_d      = (byte_in == 8'h0A) ? 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      st_q       <= S_HDR;
      idx_q      <= 2'd0;
      cnt_q      <= 16'd0;
      typ_q      <= 3'd1;
      in_frame_q <= 1'b0;
      sh_plen_q  <= '0;
      sh_chars_q <= '0;
      sh_hash_q  <= '0;
      sh_cur_q   <= '0;
      sh_ntc_q   <= '0;
      sh_hc_q    <= '0;
      sh_md4_q   <= '0;
      plen_q     <= '0;
      chars_q    <= '0;
      hash_q     <= '0;
      cur_q      <= '0;
      ntc_q      <= '0;
      hc_q       <= '0;
      md4_q      <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
      errc_q     <= 8'd0;
    end else begin
      st_q       <= st_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      typ_q      <= typ_d;
      in_frame_q <= in_frame_d;
      sh_plen_q  <= sh_plen_d;
      sh_chars_q <= sh_chars_d;
      sh_hash_q  <= sh_hash_d;
      sh_cur_q   <= sh_cur_d;
      sh_ntc_q   <= sh_ntc_d;
      sh_hc_q    <= sh_hc_d;
      sh_md4_q   <= sh_md4_d;
      plen_q     <= plen_d;
      chars_q    <= chars_d;
      hash_q     <= hash_d;
      cur_q      <= cur_d;
      ntc_q      <= ntc_d;
      hc_q       <= hc_d;
      md4_q      <= md4_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
      errc_q     <= errc_d;
    end
  end

  assign password_len      = plen_q;
  assign password_chars    = chars_q;
  assign hashes_window     = hash_q;
  assign current_hash      = cur_q;
  assign ntcrackfpga_state = ntc_q;
  assign hashchecker_state = hc_q;
  assign md4block_step     = md4_q;
  assign frame_ok          = ok_q;
  assign frame_err         = err_q;
  assign locked            = locked_q;
  assign err_count         = errc_q;

endmodule

// File: tb/tb_state_taker.sv
// tb_state_taker: randomized frame stream against a position-based frame model.
// Drives state_taker byte by byte and checks pulses, fields and counters.
module tb_state_taker;

  localparam int HB = 32;
  localparam int FL = 25 + 1 + 20 + HB + 16 + 3 + 4;
  localparam int FW = 5 + 160 + 8*HB + 128 + 5 + 4 + 6;

  typedef logic [7:0] frame_t [FL];

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic [7:0] byte_in = 8'd0;
  logic byte_valid = 1'b0;
  logic [4:0] password_len;
  logic [159:0] password_chars;
  logic [8*HB-1:0] hashes_window;
  logic [127:0] current_hash;
  logic [4:0] ntcrackfpga_state;
  logic [3:0] hashchecker_state;
  logic [5:0] md4block_step;
  logic frame_ok, frame_err, locked;
  logic [7:0] err_count;
  logic [FW-1:0] dut_f;

  always #5 clk = ~clk;

  state_taker #(.HASH_BYTES(HB)) dut (
    .clk(clk), .nrst(nrst),
    .byte_in(byte_in), .byte_valid(byte_valid),
    .password_len(password_len),
    .password_chars(password_chars),
    .hashes_window(hashes_window),
    .current_hash(current_hash),
    .ntcrackfpga_state(ntcrackfpga_state),
    .hashchecker_state(hashchecker_state),
    .md4block_step(md4block_step),
    .frame_ok(frame_ok), .frame_err(frame_err),
    .locked(locked), .err_count(err_count)
  );

  assign dut_f = {password_len, password_chars, hashes_window,
                  current_hash, ntcrackfpga_state,
                  hashchecker_state, md4block_step};

  // Frame template: fixed bytes plus a payload mask, indexed by position.
  logic [7:0] tmpl [FL];
  bit         is_pay [FL];
  int         off [6];

  // Model state.
  int pos;
  logic [7:0] fb [FL];
  logic [FW-1:0] m_fields;
  logic m_locked;
  logic [7:0] m_errc;
  logic exp_ok, exp_err;
  int m_nok;

  int compared = 0, mism = 0;
  int pulse_bad = 0, state_bad = 0;
  int n_ok = 0, n_err = 0, first_err = -1;
  logic last_ok = 1'b0;

  function automatic int rec_len(input int r);
    case (r)
      1: return 1;
      2: return 20;
      3: return HB;
      4: return 16;
      default: return 3;
    endcase
  endfunction

  task automatic build_tmpl();
    logic [7:0] hdr [4];
    logic [7:0] ftr [4];
    int p;
    hdr[0] = 8'h0A; hdr[1] = 8'h55; hdr[2] = 8'hFA; hdr[3] = 8'hCE;
    ftr[0] = 8'hA2; ftr[1] = 8'h5E; ftr[2] = 8'hFA; ftr[3] = 8'hCE;
    p = 0;
    for (int r = 1; r <= 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        tmpl[p] = hdr[k]; is_pay[p] = 0; p++;
      end
      tmpl[p] = 8'(r); is_pay[p] = 0; p++;
      off[r] = p;
      for (int k = 0; k < rec_len(r); k++) begin
        tmpl[p] = 8'h00; is_pay[p] = 1; p++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      tmpl[p] = ftr[k]; is_pay[p] = 0; p++;
    end
  endtask

  task automatic model_reset();
    pos = 0; m_fields = '0; m_locked = 1'b0; m_errc = 8'd0;
    exp_ok = 1'b0; exp_err = 1'b0;
  endtask

  task automatic model_commit();
    logic [159:0] c;
    logic [8*HB-1:0] h;
    logic [127:0] u;
    for (int i = 0; i < 20; i++) c[159-8*i -: 8] = fb[off[2]+i];
    for (int i = 0; i < HB; i++) h[8*HB-1-8*i -: 8] = fb[off[3]+i];
    for (int i = 0; i < 16; i++) u[127-8*i -: 8] = fb[off[4]+i];
    m_fields = {fb[off[1]][4:0], c, h, u, fb[off[5]][4:0],
                fb[off[5]+1][3:0], fb[off[5]+2][5:0]};
    m_locked = 1'b1;
    exp_ok = 1'b1;
    m_nok++;
  endtask

  // A frame is in progress once the record-1 type byte (position 4) is accepted.
  task automatic model_eat(input logic [7:0] b);
    exp_ok = 1'b0; exp_err = 1'b0;
    if (is_pay[pos] || b == tmpl[pos]) begin
      fb[pos] = b;
      pos++;
      if (pos == FL) begin
        model_commit();
        pos = 0;
      end
    end else begin
      if (pos >= 5) begin
        exp_err = 1'b1;
        m_locked = 1'b0;
        if (m_errc != 8'hFF) m_errc++;
      end
      pos = (b == 8'h0A) ? 1 : 0;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b);
    @(negedge clk);
    byte_valid = v; byte_in = b;
    @(posedge clk);
    #1;
    if (v) model_eat(b);
    else begin exp_ok = 1'b0; exp_err = 1'b0; end
    if (frame_ok !== exp_ok || frame_err !== exp_err) pulse_bad++;
    if (dut_f !== m_fields || locked !== m_locked ||
        err_count !== m_errc) state_bad++;
    if (frame_ok === 1'b1) n_ok++;
    if (frame_err === 1'b1) n_err++;
    last_ok = frame_ok;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    nrst = 1'b0; byte_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  // mode 0: continuous, 1: two idle cycles before each byte, 2: random gaps.
  task automatic send_range(input frame_t f, input int lo,
                            input int hi, input int mode);
    int g;
    for (int i = lo; i <= hi; i++) begin
      g = (mode == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int k = 0; k < g; k++) step(1'b0, 8'($urandom));
      step(1'b1, f[i]);
      if (frame_err === 1'b1 && first_err < 0) first_err = i;
    end
  endtask

  task automatic fill_std(output frame_t f);
    for (int i = 0; i < FL; i++) f[i] = tmpl[i];
    f[off[1]] = 8'h05;
    for (int i = 0; i < 20; i++) f[off[2]+i] = 8'h41 + 8'(i);
    for (int i = 0; i < HB; i++) f[off[3]+i] = 8'(i);
    for (int i = 0; i < 16; i++) f[off[4]+i] = 8'hFF - 8'(i);
    f[off[5]] = 8'h03; f[off[5]+1] = 8'h07; f[off[5]+2] = 8'h2A;
  endtask

  task automatic fill_rand(output frame_t f);
    for (int i = 0; i < FL; i++)
      f[i] = is_pay[i] ? 8'($urandom) : tmpl[i];
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compared++;
    if (dut_f !== '0) begin
      mism++; $display("FAIL reset_fields: got %h want 0", dut_f);
    end
    compared++;
    if ({frame_ok, frame_err, locked, err_count} !== 11'd0) begin
      mism++;
      $display("FAIL reset_flags: ok=%b err=%b lock=%b cnt=%0d want 0",
               frame_ok, frame_err, locked, err_count);
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_basic();
    frame_t f;
    int ok0;
    fill_std(f);
    ok0 = n_ok;
    send_range(f, 0, FL-1, 0);
    compared++;
    if (last_ok !== 1'b1) begin
      mism++; $display("FAIL basic_latency: frame_ok=%b want 1", last_ok);
    end
    compared++;
    if (n_ok - ok0 !== 1) begin
      mism++; $display("FAIL basic_okcount: got %0d want 1", n_ok - ok0);
    end
    compared++;
    if (password_len !== 5'd5) begin
      mism++; $display("FAIL basic_plen: got %0d want 5", password_len);
    end
    compared++;
    if (password_chars[159:152] !== 8'h41) begin
      mism++;
      $display("FAIL basic_char0: got %h want 41", password_chars[159:152]);
    end
    compared++;
    if (md4block_step !== 6'h2A) begin
      mism++; $display("FAIL basic_md4: got %h want 2a", md4block_step);
    end
    compared++;
    if (locked !== 1'b1 || err_count !== 8'd0) begin
      mism++;
      $display("FAIL basic_lock: lock=%b cnt=%0d want 1/0", locked, err_count);
    end
    compared++;
    if (dut_f !== m_fields) begin
      mism++; $display("FAIL basic_fields: got %h want %h", dut_f, m_fields);
    end
  endtask

  task automatic test_sparse();
    frame_t f;
    int ok0;
    fill_std(f);
    ok0 = n_ok;
    send_range(f, 0, FL-1, 1);
    compared++;
    if (last_ok !== 1'b1 || n_ok - ok0 !== 1) begin
      mism++;
      $display("FAIL sparse_ok: last=%b n=%0d want 1/1", last_ok, n_ok - ok0);
    end
    compared++;
    if (dut_f !== m_fields) begin
      mism++; $display("FAIL sparse_fields: got %h want %h", dut_f, m_fields);
    end
  endtask

  task automatic test_overlap();
    frame_t f;
    int ok0, er0;
    fill_rand(f);
    ok0 = n_ok; er0 = n_err;
    step(1'b1, 8'h0A);
    send_range(f, 0, FL-1, 0);
    compared++;
    if (n_ok - ok0 !== 1 || n_err - er0 !== 0) begin
      mism++;
      $display("FAIL overlap: ok=%0d err=%0d want 1/0",
               n_ok - ok0, n_err - er0);
    end
    compared++;
    if (dut_f !== m_fields) begin
      mism++; $display("FAIL overlap_fields: got %h want %h", dut_f, m_fields);
    end
  endtask

  task automatic test_bad_footer();
    frame_t a, b, c;
    logic [FW-1:0] ma;
    int er0;
    apply_reset();
    fill_rand(a);
    send_range(a, 0, FL-1, 0);
    ma = m_fields;
    fill_rand(b);
    b[99] = 8'hFB;
    er0 = n_err;
    send_range(b, 0, FL-1, 0);
    compared++;
    if (n_err - er0 !== 1 || err_count !== 8'd1 || locked !== 1'b0) begin
      mism++;
      $display("FAIL footer_err: n=%0d cnt=%0d lock=%b want 1/1/0",
               n_err - er0, err_count, locked);
    end
    compared++;
    if (dut_f !== ma) begin
      mism++; $display("FAIL footer_hold: got %h want %h", dut_f, ma);
    end
    fill_rand(c);
    send_range(c, 0, FL-1, 2);
    compared++;
    if (last_ok !== 1'b1 || dut_f !== m_fields) begin
      mism++;
      $display("FAIL footer_next: ok=%b got %h want %h",
               last_ok, dut_f, m_fields);
    end
  endtask

  task automatic test_bad_type();
    frame_t f, g;
    fill_rand(f);
    f[off[3]-1] = 8'h04;
    first_err = -1;
    send_range(f, 0, FL-1, 0);
    compared++;
    if (first_err !== off[3]-1) begin
      mism++;
      $display("FAIL type_err_pos: got %0d want %0d", first_err, off[3]-1);
    end
    fill_rand(g);
    send_range(g, 0, FL-1, 0);
    compared++;
    if (last_ok !== 1'b1 || dut_f !== m_fields) begin
      mism++;
      $display("FAIL type_next: ok=%b got %h want %h",
               last_ok, dut_f, m_fields);
    end
  endtask

  task automatic test_reset_mid();
    frame_t f, g;
    int ok0, er0;
    fill_rand(f);
    send_range(f, 0, 50, 0);
    apply_reset();
    compared++;
    if (dut_f !== '0 || locked !== 1'b0 || err_count !== 8'd0 ||
        frame_ok !== 1'b0 || frame_err !== 1'b0) begin
      mism++;
      $display("FAIL midreset_clear: f=%h lock=%b cnt=%0d ok=%b err=%b want 0",
               dut_f, locked, err_count, frame_ok, frame_err);
    end
    ok0 = n_ok; er0 = n_err;
    send_range(f, 51, FL-1, 0);
    compared++;
    if (n_ok - ok0 !== 0 || n_err - er0 !== 0) begin
      mism++;
      $display("FAIL midreset_tail: ok=%0d err=%0d want 0/0",
               n_ok - ok0, n_err - er0);
    end
    fill_rand(g);
    send_range(g, 0, FL-1, 0);
    compared++;
    if (last_ok !== 1'b1 || dut_f !== m_fields) begin
      mism++;
      $display("FAIL midreset_next: ok=%b got %h want %h",
               last_ok, dut_f, m_fields);
    end
  endtask

  task automatic test_back_to_back();
    frame_t f;
    int ok0;
    ok0 = n_ok;
    for (int k = 0; k < 3; k++) begin
      fill_rand(f);
      send_range(f, 0, FL-1, 0);
    end
    compared++;
    if (n_ok - ok0 !== 3 || dut_f !== m_fields) begin
      mism++;
      $display("FAIL b2b: ok=%0d want 3 got %h want %h",
               n_ok - ok0, dut_f, m_fields);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] seq [7];
    int er0;
    seq[0] = 8'h0A; seq[1] = 8'h55; seq[2] = 8'hFA; seq[3] = 8'hCE;
    seq[4] = 8'h01; seq[5] = 8'h05; seq[6] = 8'h00;
    apply_reset();
    er0 = n_err;
    for (int k = 0; k < 260; k++)
      for (int j = 0; j < 7; j++) step(1'b1, seq[j]);
    compared++;
    if (err_count !== 8'd255 || n_err - er0 !== 260) begin
      mism++;
      $display("FAIL saturate: cnt=%0d pulses=%0d want 255/260",
               err_count, n_err - er0);
    end
  endtask

  task automatic test_random();
    frame_t f;
    int ok0, nk0;
    ok0 = n_ok; nk0 = m_nok;
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < int'($urandom_range(0, 4)); j++)
        step(1'($urandom), 8'($urandom));
      fill_rand(f);
      if ($urandom_range(0, 2) == 0)
        f[$urandom_range(0, FL-1)] = 8'($urandom);
      send_range(f, 0, FL-1, 2);
    end
    compared++;
    if (n_ok - ok0 !== m_nok - nk0) begin
      mism++;
      $display("FAIL random_commits: got %0d want %0d",
               n_ok - ok0, m_nok - nk0);
    end
    compared++;
    if (err_count !== m_errc || locked !== m_locked) begin
      mism++;
      $display("FAIL random_state: cnt=%0d lock=%b want %0d/%b",
               err_count, locked, m_errc, m_locked);
    end
  endtask

  task automatic test_stream_totals();
    compared++;
    if (pulse_bad !== 0) begin
      mism++; $display("FAIL pulse_cycles: got %0d bad want 0", pulse_bad);
    end
    compared++;
    if (state_bad !== 0) begin
      mism++; $display("FAIL field_cycles: got %0d bad want 0", state_bad);
    end
  endtask

  initial begin
    build_tmpl();
    model_reset();
    m_nok = 0;
    test_reset();
    test_basic();
    test_sparse();
    test_overlap();
    test_bad_footer();
    test_bad_type();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    test_random();
    test_stream_totals();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
